// File: rtl/wb_queue_if.sv
// Writeback request/drain bus for wb_queue: two producer request channels
// (ALU and load) plus the register-file write port the queue drains onto.
interface wb_queue_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/wb_queue.sv
// In-order writeback FIFO merging ALU and load writes onto one register-file port,
// with pending-write hazard flags. Define WB_QUEUE_FWD_EN to add operand forwarding.
module wb_queue #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  wb_queue_if.slave                bus,
  input  logic [ADDR_W-1:0]        rs1_addr,
  input  logic [ADDR_W-1:0]        rs2_addr,
  output logic                     rs1_pend,
  output logic                     rs2_pend,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_QUEUE_FWD_EN
  ,
  output logic [DATA_W-1:0]        rs1_fwd_data,
  output logic [DATA_W-1:0]        rs2_fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];
  logic [DEPTH-1:0]  entry_valid;
  logic [DEPTH-1:0]  valid_next;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     mem_idx;
  logic [CW-1:0]     free_slots;
  logic              alu_push;
  logic              mem_push;
  logic              pop;

  // Credit comes only from registered occupancy; a same-cycle pop frees nothing.
  assign free_slots    = CW'(DEPTH) - count;
  assign bus.alu_ready = (free_slots >= CW'(1));
  assign bus.mem_ready = (free_slots >= CW'(2)) ||
                         ((free_slots == CW'(1)) && !bus.alu_valid);

  assign alu_push = bus.alu_valid && bus.alu_ready;
  assign mem_push = bus.mem_valid && bus.mem_ready;
  assign pop      = (count != '0);
  assign mem_idx  = wr_ptr + PW'(alu_push);

  assign bus.wr_en   = pop;
  assign bus.wr_addr = entry_addr[rd_ptr];
  assign bus.wr_data = entry_data[rd_ptr];

  always_comb begin
    valid_next = entry_valid;
    if (pop)      valid_next[rd_ptr]  = 1'b0;
    if (alu_push) valid_next[wr_ptr]  = 1'b1;
    if (mem_push) valid_next[mem_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      wr_ptr      <= wr_ptr + PW'(alu_push) + PW'(mem_push);
      rd_ptr      <= rd_ptr + PW'(pop);
      count       <= count + CW'(alu_push) + CW'(mem_push) - CW'(pop);
      entry_valid <= valid_next;
    end
  end

  // Payload storage is deliberately unreset; the valid bits guard it.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      entry_addr[wr_ptr] <= bus.alu_addr;
      entry_data[wr_ptr] <= bus.alu_data;
    end
    if (mem_push) begin
      entry_addr[mem_idx] <= bus.mem_addr;
      entry_data[mem_idx] <= bus.mem_data;
    end
  end

  always_comb begin
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == rs1_addr)) rs1_pend = 1'b1;
      if (entry_valid[i] && (entry_addr[i] == rs2_addr)) rs2_pend = 1'b1;
    end
  end

`ifdef WB_QUEUE_FWD_EN
  // Walk oldest to youngest from rd_ptr so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    rs1_fwd_data = '0;
    rs2_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (entry_valid[idx] && (entry_addr[idx] == rs1_addr)) rs1_fwd_data = entry_data[idx];
      if (entry_valid[idx] && (entry_addr[idx] == rs2_addr)) rs2_fwd_data = entry_data[idx];
    end
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: a scoreboard queue models the FIFO contents,
// predicts ready/occupancy/hazard flags and checks every register-file write.
module tb_wb_queue;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic clk;
  logic rst_n;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic rs1_pend;
  logic rs2_pend;
  logic [$clog2(DEPTH):0] count;
`ifdef WB_QUEUE_FWD_EN
  logic [DATA_W-1:0] rs1_fwd_data;
  logic [DATA_W-1:0] rs2_fwd_data;
`endif

  wb_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  wb_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .count    (count)
`ifdef WB_QUEUE_FWD_EN
    ,
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd_data (rs2_fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t sb[$];
  int checkCount = 0;
  int errorCount = 0;
  bit lastAluTaken;
  bit lastMemTaken;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one cycle of requests, check the DUT against the scoreboard mid-cycle,
  // then advance the model across the clock edge.
  task automatic applyStimulus(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                               input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
    int  freeSlots;
    bit  expAlu, expMem, p1, p2;
    logic [DATA_W-1:0] f1, f2;
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
    #4;
    freeSlots = DEPTH - sb.size();
    expAlu = (freeSlots >= 1);
    expMem = (freeSlots >= 2) || (freeSlots == 1 && !av);
    p1 = 0; p2 = 0; f1 = '0; f2 = '0;
    foreach (sb[i]) begin
      if (sb[i].a == rs1_addr) begin p1 = 1; f1 = sb[i].d; end
      if (sb[i].a == rs2_addr) begin p2 = 1; f2 = sb[i].d; end
    end
    checkOutput("alu_ready", 32'(bus.alu_ready), 32'(expAlu));
    checkOutput("mem_ready", 32'(bus.mem_ready), 32'(expMem));
    checkOutput("count", 32'(count), 32'(sb.size()));
    checkOutput("wr_en", 32'(bus.wr_en), 32'(sb.size() != 0));
    checkOutput("rs1_pend", 32'(rs1_pend), 32'(p1));
    checkOutput("rs2_pend", 32'(rs2_pend), 32'(p2));
`ifdef WB_QUEUE_FWD_EN
    checkOutput("rs1_fwd", 32'(rs1_fwd_data), 32'(f1));
    checkOutput("rs2_fwd", 32'(rs2_fwd_data), 32'(f2));
`endif
    if (sb.size() != 0) begin
      checkOutput("wr_addr", 32'(bus.wr_addr), 32'(sb[0].a));
      checkOutput("wr_data", 32'(bus.wr_data), 32'(sb[0].d));
    end
    @(posedge clk);
    if (sb.size() != 0) void'(sb.pop_front());
    lastAluTaken = av && expAlu;
    lastMemTaken = mv && expMem;
    if (lastAluTaken) sb.push_back('{a: aa, d: ad});
    if (lastMemTaken) sb.push_back('{a: ma, d: md});
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    int tagA, tagM;
    logic [ADDR_W-1:0] aA, mA;
    logic [DATA_W-1:0] aD, mD;

    rst_n = 1'b0;
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_addr = '0; bus.mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    checkOutput("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
    checkOutput("rst_rs1_pend", 32'(rs1_pend), 32'd0);
    rst_n = 1'b1;

    // Single ALU write: visible next cycle, gone the one after.
    applyStimulus(1, 4'd3, 8'h5A, 0, '0, '0);
    idleCycles(2);

    // Dual push into empty queue: ALU entry issues before the load entry.
    applyStimulus(1, 4'd1, 8'h11, 1, 4'd2, 8'h22);
    idleCycles(3);

    // Sustained dual pushes with held requests; pointers wrap several times.
    tagA = 16; tagM = 128;
    aA = 4'(tagA); aD = 8'(tagA); mA = 4'(tagM + 7); mD = 8'(tagM);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, aA, aD, 1, mA, mD);
      if (lastAluTaken) begin tagA++; aA = 4'(tagA); aD = 8'(tagA); end
      if (lastMemTaken) begin tagM++; mA = 4'(tagM + 7); mD = 8'(tagM); end
    end
    idleCycles(5);

    // Hazard flags follow queued destinations until they drain.
    rs1_addr = 4'd5; rs2_addr = 4'd7;
    applyStimulus(1, 4'd5, 8'h55, 1, 4'd9, 8'h99);
    idleCycles(3);

    // Same destination twice: younger value is forwarded and lands last.
    rs1_addr = 4'd4; rs2_addr = 4'd9;
    applyStimulus(1, 4'd4, 8'h10, 0, '0, '0);
    applyStimulus(1, 4'd4, 8'h20, 0, '0, '0);
    idleCycles(3);

    // Asynchronous reset with three entries queued.
    applyStimulus(1, 4'd6, 8'hA1, 1, 4'd7, 8'hA2);
    applyStimulus(1, 4'd8, 8'hA3, 1, 4'd6, 8'hA4);
    rs1_addr = 4'd6; rs2_addr = 4'd8;
    bus.alu_valid = 0; bus.mem_valid = 0;
    #2;
    checkOutput("pre_rst_count", 32'(count), 32'(sb.size()));
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_rs1_pend", 32'(rs1_pend), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(3);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idleCycles(1);
    checkOutput("final_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
